// File: rtl/ldpc_pkg.sv
// Shared types and default widths for the LDPC early-termination controller.
// Stall detection is compiled in only when STALL_DETECT_EN is defined.
package ldpc_pkg;

    localparam int ET_COUNT_W   = 12;
    localparam int ET_ITER_W    = 6;
    localparam int ET_STALL_LIM = 4;

    typedef enum logic [1:0] {
        ET_NONE  = 2'd0,
        ET_CONV  = 2'd1,
        ET_MAXIT = 2'd2,
        ET_STALL = 2'd3
    } et_reason_t;

    typedef enum logic [1:0] {
        ET_IDLE = 2'd0,
        ET_RUN  = 2'd1,
        ET_DONE = 2'd2
    } et_state_t;

endpackage

// File: rtl/ldpc_stall_tracker.sv
// Lowest-count register plus consecutive non-improving iteration counter.
// Used by ldpc_early_term only when STALL_DETECT_EN is defined.
module ldpc_stall_tracker
    import ldpc_pkg::*;
#(
    parameter int COUNT_W   = ET_COUNT_W,
    parameter int STALL_LIM = ET_STALL_LIM
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               upd,
    input  logic [COUNT_W-1:0] cnt,
    output logic [COUNT_W-1:0] best_cnt,
    output logic               stall_hit
);

    localparam int SW = $clog2(STALL_LIM + 1);
    localparam logic [SW-1:0] LIM = SW'(STALL_LIM);

    logic [SW-1:0] stall_q;
    logic [SW-1:0] stall_d;
    logic          improved;

    assign improved = (cnt < best_cnt);

    always_comb begin
        stall_d = stall_q;
        if (improved)
            stall_d = '0;
        else if (stall_q >= LIM)
            stall_d = LIM;
        else
            stall_d = stall_q + SW'(1);
    end

    // Looks ahead at the count being accepted so the decision lands with it.
    assign stall_hit = (stall_d == LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_cnt <= '1;
            stall_q  <= '0;
        end else if (clear) begin
            best_cnt <= '1;
            stall_q  <= '0;
        end else if (upd) begin
            if (improved)
                best_cnt <= cnt;
            stall_q <= stall_d;
        end
    end

endmodule

// File: rtl/ldpc_early_term.sv
// LDPC iteration controller: stop on converge, max-iter, or stall.
// Define STALL_DETECT_EN to enable stall detection (reason 3).
module ldpc_early_term
    import ldpc_pkg::*;
#(
    parameter int COUNT_W   = ET_COUNT_W,
    parameter int ITER_W    = ET_ITER_W,
    parameter int STALL_LIM = ET_STALL_LIM
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ITER_W-1:0]  max_iter,
    input  logic               cnt_valid,
    input  logic [COUNT_W-1:0] cnt,
    output logic               cnt_ready,
    output logic               dec_valid,
    output logic               dec_stop,
    output logic [1:0]         reason,
    output logic [ITER_W-1:0]  iter_num,
    output logic [COUNT_W-1:0] best_cnt,
    output logic               done
);

    et_state_t   state;
    et_reason_t  reason_q;
    logic [ITER_W-1:0] max_lat;
    logic [ITER_W-1:0] iter_next;
    logic accept;
    logic conv;
    logic maxit;
    logic stall_hit;

    assign cnt_ready = (state == ET_RUN) && !dec_valid;
    // start wins over a count presented in the same cycle
    assign accept    = cnt_valid && cnt_ready && !start;
    assign iter_next = (iter_num == '1) ? iter_num
                                        : iter_num + ITER_W'(1);
    assign conv      = (cnt == '0);
    assign maxit     = (iter_next >= max_lat);
    assign reason    = reason_q;

`ifdef STALL_DETECT_EN
    ldpc_stall_tracker #(
        .COUNT_W   (COUNT_W),
        .STALL_LIM (STALL_LIM)
    ) u_stall (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (start),
        .upd       (accept),
        .cnt       (cnt),
        .best_cnt  (best_cnt),
        .stall_hit (stall_hit)
    );
`else
    assign stall_hit = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            best_cnt <= '1;
        else if (start)
            best_cnt <= '1;
        else if (accept && (cnt < best_cnt))
            best_cnt <= cnt;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ET_IDLE;
            reason_q  <= ET_NONE;
            max_lat   <= '0;
            iter_num  <= '0;
            dec_valid <= 1'b0;
            dec_stop  <= 1'b0;
            done      <= 1'b0;
        end else begin
            dec_valid <= 1'b0;
            dec_stop  <= 1'b0;
            if (start) begin
                state    <= ET_RUN;
                reason_q <= ET_NONE;
                iter_num <= '0;
                done     <= 1'b0;
                max_lat  <= (max_iter == '0) ? ITER_W'(1)
                                             : max_iter;
            end else if (accept) begin
                dec_valid <= 1'b1;
                iter_num  <= iter_next;
                if (conv) begin
                    reason_q <= ET_CONV;
                    dec_stop <= 1'b1;
                    done     <= 1'b1;
                    state    <= ET_DONE;
                end else if (maxit) begin
                    reason_q <= ET_MAXIT;
                    dec_stop <= 1'b1;
                    done     <= 1'b1;
                    state    <= ET_DONE;
                end else if (stall_hit) begin
                    reason_q <= ET_STALL;
                    dec_stop <= 1'b1;
                    done     <= 1'b1;
                    state    <= ET_DONE;
                end else begin
                    reason_q <= ET_NONE;
                end
            end
        end
    end

endmodule
